lmsm_mem_sequencer: RTL and testbench

Multi-word memory initiator that drives the 64x16 data memory's address, write-data and active-low read/write strobes. It executes load-multiple (LM) and store-multiple (SM) transfers for the processor datapath: one memory word per set bit of an 8-bit register mask, at consecutive addresses from a base. It sits between the control FSM/register file and the memory. It replaces the per-word micro-sequencing of LM/SM in the main controller.

---
 rtl/lmsm_mem_sequencer_if.sv | 47 ++++
 rtl/lmsm_mem_sequencer.sv | 128 ++++++++++++
 tb/tb_lmsm_mem_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lmsm_mem_sequencer_if.sv
// Request, memory and register-file bus of the LM/SM sequencer.
// LMSM_ADDR_WB_EN adds end_addr for base-register writeback.
interface lmsm_mem_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int NREG   = 8
);
  localparam int IDX_W = $clog2(NREG);

  logic              start;
  logic              op;
  logic [ADDR_W-1:0] base_addr;
  logic [NREG-1:0]   reg_mask;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write_n;
  logic              mem_read_n;
  logic [DATA_W-1:0] mem_rdata;
  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              done;
`ifdef LMSM_ADDR_WB_EN
  logic [ADDR_W-1:0] end_addr;
`endif

  modport master (
    input  start, op, base_addr, reg_mask, mem_rdata, rf_rdata,
    output mem_addr, mem_wdata, mem_write_n, mem_read_n,
           rf_raddr, rf_we, rf_waddr, rf_wdata, busy, done
`ifdef LMSM_ADDR_WB_EN
    , output end_addr
`endif
  );

  modport slave (
    output start, op, base_addr, reg_mask, mem_rdata, rf_rdata,
    input  mem_addr, mem_wdata, mem_write_n, mem_read_n,
           rf_raddr, rf_we, rf_waddr, rf_wdata, busy, done
`ifdef LMSM_ADDR_WB_EN
    , input end_addr
`endif
  );
endinterface

// File: rtl/lmsm_mem_sequencer.sv
// Load-multiple / store-multiple memory initiator: one word per set mask bit.
// Optional LMSM_ADDR_WB_EN registers the final address for base writeback.
//
// state | meaning
// IDLE  | waiting for start, strobes high
// XFER  | one memory word per cycle, lowest remaining mask bit first
// DONE  | one-cycle completion pulse, last load writeback lands here
module lmsm_mem_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int NREG   = 8
) (
  input logic                   clk,
  input logic                   proc_rst,
  lmsm_mem_sequencer_if.master  bus
);
  localparam int IDX_W = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              op_q;
  logic [NREG-1:0]   mask_q;
  logic [NREG-1:0]   mask_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  idx;
  logic              rf_we_q;
  logic [IDX_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              rd_n, wr_n;
  logic [ADDR_W-1:0] addr_c;
  logic [IDX_W-1:0]  raddr_c;

  // lowest set bit of the working mask
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = i[IDX_W-1:0];
    end
  end

  assign mask_nxt = mask_q & (mask_q - NREG'(1));

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    addr_c    = '0;
    raddr_c   = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.reg_mask == '0) ? DONE : XFER;
      end
      XFER: begin
        addr_c = cur_addr;
        if (op_q) begin
          wr_n    = 1'b0;
          raddr_c = idx;
        end else begin
          rd_n = 1'b0;
        end
        if (mask_nxt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      op_q       <= 1'b0;
      mask_q     <= '0;
      cur_addr   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_q     <= bus.op;
        mask_q   <= bus.reg_mask;
        cur_addr <= bus.base_addr;
      end else if (state == XFER) begin
        mask_q   <= mask_nxt;
        cur_addr <= cur_addr + ADDR_W'(1);
      end
      // load data arrives in the read cycle and is written back one cycle later
      rf_we_q <= (state == XFER) && !op_q;
      if (state == XFER && !op_q) begin
        rf_waddr_q <= idx;
        rf_wdata_q <= bus.mem_rdata;
      end
    end
  end

`ifdef LMSM_ADDR_WB_EN
  logic [ADDR_W-1:0] end_addr_q;

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      end_addr_q <= '0;
    end else if (state_nxt == DONE && state != DONE) begin
      end_addr_q <= (state == IDLE) ? bus.base_addr : cur_addr + ADDR_W'(1);
    end
  end

  assign bus.end_addr = end_addr_q;
`endif

  assign bus.mem_read_n  = rd_n;
  assign bus.mem_write_n = wr_n;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_wdata   = bus.rf_rdata;
  assign bus.rf_raddr    = raddr_c;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_lmsm_mem_sequencer.sv
// Scoreboard bench for lmsm_mem_sequencer with memory and register-file models.
module tb_lmsm_mem_sequencer;
  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [15:0] data;
  } acc_t;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
  } rfw_t;

  logic clk = 1'b0;
  logic proc_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  acc_t acc_q[$];
  rfw_t rfw_q[$];
  int   done_q[$];

  logic [15:0] mem[64];
  logic [15:0] rf[8];
  logic        pm_en = 1'b0, pr_en = 1'b0;
  logic [5:0]  pm_a = '0;
  logic [2:0]  pr_a = '0;
  logic [15:0] pm_d = '0, pr_d = '0;

  lmsm_mem_sequencer_if bus();

  lmsm_mem_sequencer dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // memory samples on negedge, read data valid after negedge of the read cycle
  always @(negedge clk) begin
    if (pm_en) mem[pm_a] <= pm_d;
    else if (!bus.mem_write_n) mem[bus.mem_addr] <= bus.mem_wdata;
    if (!bus.mem_read_n) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (pr_en) rf[pr_a] <= pr_d;
    else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
  end

  assign bus.rf_rdata = rf[bus.rf_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with nothing expected at %0t", name, $time);
  endtask

  task automatic poke_m(input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pm_en = 1'b1; pm_a = a; pm_d = d;
    @(negedge clk); #1;
    pm_en = 1'b0;
  endtask

  task automatic poke_r(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk); #1;
    pr_en = 1'b1; pr_a = a; pr_d = d;
    @(posedge clk); #1;
    pr_en = 1'b0;
  endtask

  // monitor: pop and compare whenever the DUT presents a memory access, rf write or done
  initial begin
    acc_t e;
    rfw_t r;
    int   d;
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_read_n && !bus.mem_write_n) unexpected("both_strobes_low");
      if (!bus.busy) chk("idle_strobes", {30'd0, bus.mem_read_n, bus.mem_write_n}, 32'd3);
      if (!bus.mem_read_n || !bus.mem_write_n) begin
        if (acc_q.size() == 0) unexpected("mem_access");
        else begin
          e = acc_q.pop_front();
          chk("acc_is_write", {31'd0, ~bus.mem_write_n}, {31'd0, e.wr});
          chk("acc_addr", {26'd0, bus.mem_addr}, {26'd0, e.addr});
          if (e.wr) chk("acc_wdata", {16'd0, bus.mem_wdata}, {16'd0, e.data});
        end
      end
      if (bus.rf_we) begin
        if (rfw_q.size() == 0) unexpected("rf_write");
        else begin
          r = rfw_q.pop_front();
          chk("rf_waddr", {29'd0, bus.rf_waddr}, {29'd0, r.idx});
          chk("rf_wdata", {16'd0, bus.rf_wdata}, {16'd0, r.data});
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          d = done_q.pop_front();
          chk("done_busy", {31'd0, bus.busy}, 32'd1);
`ifdef LMSM_ADDR_WB_EN
          chk("end_addr", {26'd0, bus.end_addr}, d);
`endif
        end
      end
    end
  end

  // reference: word k of the transfer goes to (base + k) mod 64, registers in ascending order
  task automatic expect_xfer(input bit op, input logic [5:0] base, input logic [7:0] mask);
    int k = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        acc_t a;
        rfw_t w;
        a.wr   = op;
        a.addr = 6'((int'(base) + k) % 64);
        a.data = op ? rf[i] : 16'h0;
        acc_q.push_back(a);
        if (!op) begin
          w.idx  = 3'(i);
          w.data = mem[a.addr];
          rfw_q.push_back(w);
        end
        k++;
      end
    end
    done_q.push_back((int'(base) + $countones(mask)) % 64);
  endtask

  task automatic run_xfer(input bit op, input logic [5:0] base, input logic [7:0] mask,
                          input bit inject);
    int n = $countones(mask);
    int e = 0;
    int busy_cnt = 0;
    expect_xfer(op, base, mask);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.base_addr = base; bus.reg_mask = mask;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (n > 0) chk("first_strobe", {31'd0, bus.mem_read_n & bus.mem_write_n}, 32'd0);
    forever begin
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
      if (e > 20) begin
        unexpected("done_timeout");
        break;
      end
      if (inject && e == 1) begin
        @(negedge clk);
        bus.start = 1'b1; bus.op = ~op; bus.base_addr = 6'($urandom); bus.reg_mask = 8'hFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      e++;
    end
    chk("done_latency", e, n);
    chk("busy_cycles", busy_cnt, n + 1);
    @(posedge clk); #1;
    chk("idle_after_done", {31'd0, bus.busy}, 32'd0);
    chk("acc_q_drained", acc_q.size(), 0);
    chk("rfw_q_drained", rfw_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
  endtask

  initial begin
    logic [15:0] old1;
    bus.start = 1'b0; bus.op = 1'b0; bus.base_addr = '0; bus.reg_mask = '0;
    #1;
    chk("rst_read_n", {31'd0, bus.mem_read_n}, 32'd1);
    chk("rst_write_n", {31'd0, bus.mem_write_n}, 32'd1);
    chk("rst_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
    chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst_rf_waddr", {29'd0, bus.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", {16'd0, bus.rf_wdata}, 32'd0);
    chk("rst_rf_raddr", {29'd0, bus.rf_raddr}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef LMSM_ADDR_WB_EN
    chk("rst_end_addr", {26'd0, bus.end_addr}, 32'd0);
`endif
    for (int i = 0; i < 64; i++) poke_m(6'(i), 16'($urandom));
    for (int i = 0; i < 8; i++) poke_r(3'(i), 16'($urandom));
    poke_m(6'd20, 16'h0001);
    poke_m(6'd21, 16'h2E56);
    poke_r(3'd1, 16'hAAAA);
    poke_r(3'd7, 16'h5555);
    @(negedge clk);
    proc_rst = 1'b1;
    repeat (2) @(posedge clk);

    run_xfer(1'b0, 6'd20, 8'b0000_0101, 1'b0);
    chk("t1_r0", {16'd0, rf[0]}, 32'h0001);
    chk("t1_r2", {16'd0, rf[2]}, 32'h2E56);

    run_xfer(1'b1, 6'd23, 8'b1000_0010, 1'b0);
    chk("t2_mem23", {16'd0, mem[23]}, 32'hAAAA);
    chk("t2_mem24", {16'd0, mem[24]}, 32'h5555);

    run_xfer(1'b0, 6'd62, 8'hFF, 1'b0);
    run_xfer(1'b0, 6'd9, 8'h00, 1'b0);
    run_xfer(1'b1, 6'd40, 8'b0110_1101, 1'b1);

    for (int t = 0; t < 25; t++) begin
      logic [7:0] m = 8'($urandom);
      if (t % 6 == 0) m = 8'h00;
      run_xfer(1'(($urandom)), 6'($urandom), m, 1'($urandom_range(0, 3) == 0));
    end

    // abort an 8-word store in its second transfer cycle
    old1 = mem[1];
    expect_xfer(1'b1, 6'd0, 8'hFF);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.base_addr = 6'd0; bus.reg_mask = 8'hFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    proc_rst = 1'b0;
    #1;
    chk("abort_read_n", {31'd0, bus.mem_read_n}, 32'd1);
    chk("abort_write_n", {31'd0, bus.mem_write_n}, 32'd1);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    acc_q.delete();
    rfw_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    proc_rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_mem0_written", {16'd0, mem[0]}, {16'd0, rf[0]});
    chk("abort_mem1_untouched", {16'd0, mem[1]}, {16'd0, old1});
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);

    run_xfer(1'b1, 6'd5, 8'b0011_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000");
    $fatal(1, "timeout");
  end
endmodule
